// File: rtl/serial_adder4_pkg.sv
// rtl/serial_adder4_pkg.sv - shared constants and state encoding for the serial adder
package serial_adder4_pkg;

   localparam int WIDTH = 4;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_adder4_if.sv
// rtl/serial_adder4_if.sv - operand/result bundle between requester and serial adder
interface serial_adder4_if;
   import serial_adder4_pkg::*;

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, cin,
      input  sum, cout, ovf, zero, neg, busy, done
   );

   modport slave (
      input  start, a, b, cin,
      output sum, cout, ovf, zero, neg, busy, done
   );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full adder
module full_adder (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder4.sv
// rtl/serial_adder4.sv - bit-serial 4-bit adder with carry, overflow, zero and sign flags
module serial_adder4 #(
   parameter int WIDTH = serial_adder4_pkg::WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   serial_adder4_if.slave bus
);
   import serial_adder4_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;
   logic [WIDTH-1:0]   w_next_acc;
   logic               w_sum_bit;
   logic               w_carry_out;
   logic               w_busy;
   logic               w_done;

   full_adder u_fa (
      .sum  (w_sum_bit),
      .cout (w_carry_out),
      .a    (r_a[r_idx]),
      .b    (r_b[r_idx]),
      .cin  (r_carry)
   );

   // Working sum with the bit for the current index replaced by the adder output
   always_comb begin
      w_next_acc        = r_acc;
      w_next_acc[r_idx] = w_sum_bit;
   end

   // State register; the illegal encoding falls back to IDLE through the next-state logic
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: IDLE waits for start, RUN walks four bits, DONE lasts one cycle
   always_comb begin
      w_next_state = ST_IDLE;
      case (r_state)
         ST_IDLE: w_next_state = bus.start ? ST_RUN : ST_IDLE;
         ST_RUN:  w_next_state = (r_idx == LAST_IDX) ? ST_DONE : ST_RUN;
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the current state only
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_RUN:  w_busy = 1'b1;
         ST_DONE: w_done = 1'b1;
         default: begin
            w_busy = 1'b0;
            w_done = 1'b0;
         end
      endcase
   end

   // Datapath: latch operands on accept, add one bit per RUN edge, publish flags on the last bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_carry <= bus.cin;
                  r_idx   <= '0;
                  r_acc   <= '0;
               end
            end
            ST_RUN: begin
               r_acc   <= w_next_acc;
               r_carry <= w_carry_out;
               r_idx   <= r_idx + IDX_W'(1);
               if (r_idx == LAST_IDX) begin
                  r_sum  <= w_next_acc;
                  r_cout <= w_carry_out;
                  r_ovf  <= r_carry ^ w_carry_out;
               end
            end
            default: begin
               r_idx <= r_idx;
            end
         endcase
      end
   end

   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;
   assign bus.zero = (r_sum == '0);
   assign bus.neg  = r_sum[WIDTH-1];
   assign bus.busy = w_busy;
   assign bus.done = w_done;

endmodule

// File: doc/serial_adder4.md
SERIAL_ADDER4 -- requirements
Module: serial_adder4

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits; the only supported value is 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 SHALL have port a, input, 4 bits: two's-complement augend.
REQ-006 SHALL have port b, input, 4 bits: two's-complement addend.
REQ-007 SHALL have port cin, input, 1 bit: carry-in.
REQ-008 SHALL have port sum, output, 4 bits: registered result.
REQ-009 SHALL have port cout, output, 1 bit: carry out of bit 3.
REQ-010 SHALL have port ovf, output, 1 bit: signed overflow.
REQ-011 SHALL have port zero, output, 1 bit: sum == 0.
REQ-012 SHALL have port neg, output, 1 bit: equals sum[3].
REQ-013 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement the states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 at a clock edge SHALL latch a, b and cin, clear bit index to 0, clear the sum shift register, and enter RUN.
REQ-017 In RUN, each edge SHALL add a_reg[idx] + b_reg[idx] + carry_reg using one full-adder bit, write the sum bit to position idx, update carry_reg, and increment idx.
REQ-018 At the edge that processes idx=3, the block SHALL capture cout as the carry out, capture ovf as carry-into-bit3 XOR carry-out-of-bit3, and enter DONE.
REQ-019 The block SHALL take exactly 4 edges in RUN, so done is high during the cycle after the 5th edge counted from the accepting edge.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-022 start SHALL be ignored in RUN and DONE: no re-latch, no queueing.
REQ-023 A start asserted in the IDLE cycle that follows DONE SHALL be accepted normally.
REQ-024 Operand and cin changes after acceptance SHALL NOT affect the result.
REQ-025 The outputs sum, cout, ovf, zero and neg SHALL hold their last completed values from DONE until the next accepting edge.
REQ-026 The outputs sum, cout, ovf, zero and neg are undefined-but-stable during RUN, and consumers SHALL sample them only when done=1.
REQ-027 Arithmetic SHALL be modulo 2^4; cout and ovf SHALL be independent flags.
REQ-028 zero and neg SHALL be derived combinationally from the registered sum.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, idx=0, carry_reg=0, sum=0, cout=0, ovf=0, busy=0 and done=0; zero therefore reads 1 and neg reads 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-031 After reset deasserts, the first edge with start=1 SHALL be accepted.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), WIDTH=4, and the index width of 2.
REQ-033 The single-bit add SHALL be a sub-module named full_adder (ports sum, cout, a, b, cin), combinational, instantiated once.
REQ-034 Unreachable state 2'b11 SHALL recover to IDLE at the next edge.

Verification
REQ-035 The bench SHALL drive a=0011, b=0100, cin=0 -> done after 5 edges; sum=0111, cout=0, ovf=0, zero=0, neg=0.
REQ-036 The bench SHALL drive a=0111, b=0001, cin=0 -> sum=1000, cout=0, ovf=1, neg=1.
REQ-037 The bench SHALL drive a=1000, b=1111, cin=0 -> sum=0111, cout=1, ovf=1, neg=0.
REQ-038 The bench SHALL drive a=1101, b=0011, cin=0 -> sum=0000, cout=1, ovf=0, zero=1; and a=1111, b=0000, cin=1 -> sum=0000, cout=1, ovf=0.
REQ-039 The bench SHALL start 0001+0001, change a to 0111 and pulse start during RUN -> sum=0010, exactly one done pulse; a start in the following IDLE cycle is accepted.
REQ-040 The bench SHALL assert rst=0 at the 2nd RUN edge -> busy=0, done=0 and sum=0 immediately, no done pulse; a subsequent 0010+0011 gives sum=0101.
